// File: rtl/mul_pkg.sv
// mul_pkg: FSM state encoding shared by the sequential arithmetic units
package mul_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mul_step.sv
// mul_step: one shift-add iteration; the add carry enters the product MSB
module mul_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] rp,
  input  logic [WIDTH-1:0]   ra,
  output logic [2*WIDTH-1:0] rp_n
);
  logic [WIDTH:0] sum;
  assign sum  = {1'b0, rp[2*WIDTH-1:WIDTH]} + {1'b0, rp[0] ? ra : WIDTH'(0)};
  assign rp_n = {sum, rp[WIDTH-1:1]};
endmodule

// File: rtl/mul.sv
// mul: sequential shift-add unsigned multiplier, one multiplier bit per clock
module mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] y,
  output logic               busy,
  output logic               done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t             state, nxt;
  logic [WIDTH-1:0]   ra;
  logic [2*WIDTH-1:0] rp, rp_n;
  logic [CW-1:0]      cnt;
  logic               acc, last;
  assign acc  = ld && (state == ST_IDLE || state == ST_DONE);
  assign last = (state == ST_RUN) && (cnt == CW'(WIDTH-1));
  assign busy = state == ST_RUN;
  assign done = state == ST_DONE;
  mul_step #(.WIDTH(WIDTH)) u_step (.rp(rp), .ra(ra), .rp_n(rp_n));
  always_comb begin
    nxt = ST_IDLE;
    nxt = acc ? ST_RUN : last ? ST_DONE : (state == ST_RUN) ? ST_RUN : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ra    <= '0;
      rp    <= '0;
      cnt   <= '0;
      y     <= '0;
    end else begin
      state <= nxt;
      if (acc) begin
        ra  <= a;
        rp  <= {WIDTH'(0), b};
        cnt <= '0;
      end else if (state == ST_RUN) begin
        rp  <= rp_n;
        cnt <= cnt + CW'(1);
        if (last) y <= rp_n;
      end
    end
  end
endmodule

// File: tb/tb_mul.sv
// tb_mul: scoreboard bench for mul at WIDTH=4 and WIDTH=8 against plain a*b
module tb_mul;
  typedef struct {
    int unsigned p;
    int unsigned due;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic ld4 = 0, ld8 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic [7:0] y4;
  logic [15:0] y8;
  logic busy4, done4, busy8, done8;
  int checks = 0, errors = 0;
  int unsigned cyc = 0;
  exp_t q4[$], q8[$];

  mul #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .ld(ld4), .a(a4), .b(b4), .y(y4), .busy(busy4), .done(done4));
  mul #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .ld(ld8), .a(a8), .b(b8), .y(y8), .busy(busy8), .done(done8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      if (q4.size() == 0) chk("spurious_done4", 32'(done4), 32'd0);
      else begin
        e = q4.pop_front();
        chk("y4", 32'(y4), e.p);
        chk("latency4", cyc, e.due);
      end
    end
    if (done8) begin
      if (q8.size() == 0) chk("spurious_done8", 32'(done8), 32'd0);
      else begin
        e = q8.pop_front();
        chk("y8", 32'(y8), e.p);
        chk("latency8", cyc, e.due);
      end
    end
  end

  // call just after a negedge; returns at the negedge following the accepting edge
  task automatic start(bit w8, int unsigned x, int unsigned z);
    exp_t e;
    e.p = w8 ? (x % 256) * (z % 256) : (x % 16) * (z % 16);
    e.due = cyc + 1 + (w8 ? 8 : 4);
    if (w8) begin a8 = 8'(x); b8 = 8'(z); ld8 = 1; q8.push_back(e); end
    else begin a4 = 4'(x); b4 = 4'(z); ld4 = 1; q4.push_back(e); end
    @(negedge clk);
    ld4 = 0;
    ld8 = 0;
    a4 = 4'($urandom);
    b4 = 4'($urandom);
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  task automatic wait_done(bit w8);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = w8 ? done8 : done4;
    end
    if (!seen) chk(w8 ? "timeout8" : "timeout4", 32'd0, 32'd1);
  endtask

  task automatic run_check(bit w8, int unsigned x, int unsigned z, int unsigned p);
    int w = w8 ? 8 : 4;
    start(w8, x, z);
    for (int i = 0; i < w; i++) begin
      chk("busy_run", 32'(w8 ? busy8 : busy4), 32'd1);
      chk("done_run", 32'(w8 ? done8 : done4), 32'd0);
      @(negedge clk);
    end
    chk("done_pulse", 32'(w8 ? done8 : done4), 32'd1);
    chk("busy_done", 32'(w8 ? busy8 : busy4), 32'd0);
    @(negedge clk);
    chk("done_after", 32'(w8 ? done8 : done4), 32'd0);
    chk("busy_after", 32'(w8 ? busy8 : busy4), 32'd0);
    chk("y_hold", w8 ? 32'(y8) : 32'(y4), p);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_y4", 32'(y4), 0);
    chk("rst_busy4", 32'(busy4), 0);
    chk("rst_done4", 32'(done4), 0);
    chk("rst_y8", 32'(y8), 0);
    chk("rst_busy8", 32'(busy8), 0);
    run_check(0, 3, 5, 8'h0F);
    run_check(0, 15, 15, 8'hE1);
    run_check(0, 0, 9, 0);
    // ld during RUN must be ignored
    start(0, 7, 6);
    @(negedge clk);
    a4 = 2; b4 = 2; ld4 = 1;
    @(negedge clk);
    ld4 = 0;
    wait_done(0);
    repeat (8) @(negedge clk);
    chk("ignored_ld_y", 32'(y4), 8'h2A);
    // back-to-back: new ld in the done cycle
    start(0, 3, 5);
    wait_done(0);
    start(0, 4, 4);
    chk("b2b_busy", 32'(busy4), 1);
    wait_done(0);
    @(negedge clk);
    chk("b2b_y", 32'(y4), 8'h10);
    // reset mid-run discards the operation
    start(0, 11, 13);
    repeat (2) @(negedge clk);
    rst = 1;
    q4.delete();
    q8.delete();
    @(negedge clk);
    rst = 0;
    chk("midrst_busy", 32'(busy4), 0);
    chk("midrst_done", 32'(done4), 0);
    chk("midrst_y", 32'(y4), 0);
    repeat (8) @(negedge clk);
    run_check(0, 9, 9, 8'h51);
    run_check(1, 255, 255, 16'hFE01);
    for (int i = 0; i < 200; i++) begin
      start(1, $urandom_range(0, 255), $urandom_range(0, 255));
      wait_done(1);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    for (int i = 0; i < 60; i++) begin
      start(0, $urandom_range(0, 15), $urandom_range(0, 15));
      wait_done(0);
    end
    repeat (3) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
